// File: rtl/seq_det_pkg.sv
// Shared helpers for the programmable sequence detector: length-field sizing
// and clamping of a requested pattern length to the supported maximum.
package seq_det_pkg;

  function automatic int unsigned len_width(input int unsigned max_len);
    return $clog2(max_len + 1);
  endfunction

  function automatic int unsigned clamp_len(input int unsigned len,
                                            input int unsigned max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/seq_prefix_match.sv
// Combinational prefix search: longest pattern prefix that equals the tail of
// the history, limited by the number of valid history bits.
module seq_prefix_match
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4
) (
  input  logic [MAX_LEN-1:0] hist,
  input  logic [LEN_W-1:0]   fill,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  output logic               full_match,
  output logic [LEN_W-1:0]   prefix_len
);

  logic [MAX_LEN-1:0] mask;
  logic [MAX_LEN-1:0] aligned;
  logic               found;

  // NOTE: every variable written here gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    prefix_len = '0;
    mask       = '0;
    aligned    = '0;
    found      = 1'b0;
    // Search from the longest candidate down; the first hit is the answer.
    for (int k = MAX_LEN; k >= 1; k--) begin
      if (!found && (k <= int'(len)) && (k <= int'(fill))) begin
        mask    = {MAX_LEN{1'b1}} >> (MAX_LEN - k);
        aligned = pattern >> (int'(len) - k);
        if ((hist & mask) == (aligned & mask)) begin
          prefix_len = LEN_W'(k);
          found      = 1'b1;
        end
      end
    end
    full_match = (len != '0) && (prefix_len == len);
  end

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial sequence detector with overlap control,
// registered match pulse, saturating match counter and prefix-length display.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter  int MAX_LEN = 8,
  parameter  int CNT_W   = 8,
  localparam int LEN_W   = len_width(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               din_valid,
  input  logic               din,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt,
  output logic [LEN_W-1:0]   prefix_len
);

  logic [MAX_LEN-1:0] pattern_q;
  logic [LEN_W-1:0]   len_q;
  logic               overlap_q;

  logic [MAX_LEN-1:0] hist_q;
  logic [MAX_LEN-1:0] hist_next;
  logic [LEN_W-1:0]   fill_q;
  logic [LEN_W-1:0]   fill_next;

  logic               take;
  logic               full_match;
  logic               hit;
  logic               restart;
  logic [LEN_W-1:0]   prefix_next;

  always_comb begin
    hist_next = {hist_q[MAX_LEN-2:0], din};
    fill_next = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);
    take      = din_valid && !cfg_load;
    hit       = take && full_match;
    // A non-overlapping match consumes its bits: start the next search empty.
    restart   = full_match && !overlap_q;
  end

  seq_prefix_match #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_prefix (
    .hist       (hist_next),
    .fill       (fill_next),
    .pattern    (pattern_q),
    .len        (len_q),
    .full_match (full_match),
    .prefix_len (prefix_next)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  // The history is reset as well, so a partial match never survives rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pattern_q  <= '0;
      len_q      <= '0;
      overlap_q  <= 1'b0;
      hist_q     <= '0;
      fill_q     <= '0;
      match      <= 1'b0;
      prefix_len <= '0;
    end else if (cfg_load) begin
      pattern_q  <= cfg_pattern;
      len_q      <= LEN_W'(clamp_len(32'(cfg_len), MAX_LEN));
      overlap_q  <= cfg_overlap;
      hist_q     <= '0;
      fill_q     <= '0;
      match      <= 1'b0;
      prefix_len <= '0;
    end else if (din_valid) begin
      hist_q     <= hist_next;
      fill_q     <= restart ? '0 : fill_next;
      match      <= full_match;
      prefix_len <= restart ? '0 : prefix_next;
    end else begin
      match      <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_cnt <= '0;
    end else if (cnt_clr) begin
      match_cnt <= '0;
    end else if (hit && (match_cnt != '1)) begin
      match_cnt <= match_cnt + CNT_W'(1);
    end
  end

endmodule
